// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: turns the asynchronous PLL `locked` flag into a clean,
// registered system reset/ready pair for logic in the PLL output clock domain.
// Lock must be stable for STABLE_CYCLES before release, short dropouts in RUN
// are filtered, and a real loss forces at least HOLD_CYCLES of reset.
// Optional feature: define LOCK_MON_CNT_EN to add a saturating loss_count port.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int DROP_FILTER   = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    input  logic             clr_lost,
    output logic             sys_rst,
    output logic             ready,
    output logic             lock_lost,
    output logic [1:0]       state
`ifdef LOCK_MON_CNT_EN
    ,
    output logic [CNT_W-1:0] loss_count
`endif
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RUN       = 2'd2,
        ST_HOLD      = 2'd3
    } state_t;

    // The shared counter only ever needs to reach (largest interval - 1).
    localparam int MAX_SD  = (STABLE_CYCLES > DROP_FILTER) ? STABLE_CYCLES : DROP_FILTER;
    localparam int MAX_ALL = (MAX_SD > HOLD_CYCLES) ? MAX_SD : HOLD_CYCLES;
    localparam int CW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] DROP_LAST   = CW'(DROP_FILTER - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_sys_rst;
    logic                   r_ready;
    logic                   r_lock_lost;

    logic                   w_lk_s;
    state_t                 w_next_state;
    logic [CW-1:0]          w_cnt_next;
    logic                   w_loss;

    // Shift chain that brings the asynchronous lock flag into the clk domain.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
        end
    end

    assign w_lk_s = r_sync[SYNC_STAGES-1];

    // Next-state and shared counter decode; counter restarts on any state change.
    // NOTE: defaults are assigned first so every path drives every output,
    // otherwise the missing paths would infer latches.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt + CW'(1);
        case (r_state)
            ST_WAIT_LOCK: begin
                w_cnt_next = r_cnt;
                if (w_lk_s) w_next_state = ST_STABLE;
            end
            ST_STABLE: begin
                if (!w_lk_s)                  w_next_state = ST_WAIT_LOCK;
                else if (r_cnt == STABLE_LAST) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (w_lk_s)                  w_cnt_next   = '0;
                else if (r_cnt == DROP_LAST) w_next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_cnt == HOLD_LAST) w_next_state = ST_WAIT_LOCK;
            end
            default: begin
                w_next_state = ST_WAIT_LOCK;
            end
        endcase
        if (w_next_state != r_state) w_cnt_next = '0;
    end

    assign w_loss = (r_state == ST_RUN) && (w_next_state == ST_HOLD);

    // FSM state, counter and outputs, all registered from next-state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= '0;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_cnt_next;
            r_sys_rst <= (w_next_state != ST_RUN);
            r_ready   <= (w_next_state == ST_RUN);
            // A loss on the same edge as a clear must remain visible.
            if (w_loss)        r_lock_lost <= 1'b1;
            else if (clr_lost) r_lock_lost <= 1'b0;
        end
    end

    assign sys_rst   = r_sys_rst;
    assign ready     = r_ready;
    assign lock_lost = r_lock_lost;
    assign state     = r_state;

`ifdef LOCK_MON_CNT_EN
    logic [CNT_W-1:0] r_loss_count;

    // Saturating count of RUN->HOLD losses; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_loss_count <= '0;
        end else if (w_loss && (r_loss_count != '1)) begin
            r_loss_count <= r_loss_count + CNT_W'(1);
        end
    end

    assign loss_count = r_loss_count;
`endif

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Consumes the PLL `locked` indication in the PLL output clock domain (10 MHz) and produces the system reset and ready for all downstream logic.
- Synchronizes the asynchronous `locked` input.
- Holds `sys_rst` asserted until lock has been stable for a programmable interval.
- Filters short lock dropouts.
- On real lock loss, forces a minimum-length reset and records a sticky loss flag.

Parameters:
SYNC_STAGES, 2, synchronizer flop count for `locked`; legal ≥2
STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release; legal ≥1
DROP_FILTER, 4, consecutive synchronized-unlock cycles in RUN that count as a lock loss; legal ≥1
HOLD_CYCLES, 16, minimum cycles spent in HOLD after a loss; legal ≥1
CNT_W, 8, width of loss_count (optional feature only)

Ports:
clk  input  1  PLL output clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
locked  input  1  PLL lock flag, asynchronous to clk
clr_lost  input  1  single-cycle pulse; clears lock_lost
sys_rst  output  1  registered system reset, active-high
ready  output  1  registered; always equal to ~sys_rst
lock_lost  output  1  sticky; set on every RUN->HOLD transition
state  output  2  current FSM state: 0 WAIT_LOCK, 1 STABLE, 2 RUN, 3 HOLD
loss_count  output  CNT_W  count of lock losses (present only with LOCK_MON_CNT_EN)

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values (applied at the next edge with rst=1, from any state, including mid-operation):
  - sync flops 0, state WAIT_LOCK, all internal counters 0
  - sys_rst=1, ready=0, lock_lost=0, loss_count=0
- Synchronizer: `locked` passes through SYNC_STAGES flops; the last stage is lk_s. No other logic samples `locked` directly.
- One shared cycle counter, sized to clog2 of max(STABLE_CYCLES, HOLD_CYCLES, DROP_FILTER). It is cleared on every state change.
- WAIT_LOCK: lk_s=1 -> STABLE; otherwise stay.
- STABLE:
  - lk_s=0 -> WAIT_LOCK. No loss event; lock_lost unchanged.
  - lk_s=1 and cnt==STABLE_CYCLES-1 -> RUN.
  - Otherwise cnt++.
- RUN:
  - lk_s=1 clears cnt.
  - lk_s=0 with cnt==DROP_FILTER-1 -> HOLD (loss event).
  - lk_s=0 otherwise: cnt++.
  - DROP_FILTER=1 means a single low cycle is a loss.
- HOLD: ignores lk_s. At cnt==HOLD_CYCLES-1 -> WAIT_LOCK; otherwise cnt++. HOLD lasts exactly HOLD_CYCLES cycles.
- Outputs are driven from next-state, so they change on the same edge as state:
  - sys_rst=0 iff next state is RUN.
  - ready = ~sys_rst.
- Release latency: with `locked` held high, count the first edge that samples locked=1 as edge 1. sys_rst falls at edge SYNC_STAGES+STABLE_CYCLES+1 (1027 at defaults).
- Loss latency: locked falls before edge k and stays low. sys_rst rises at edge k+SYNC_STAGES+DROP_FILTER-1.
- sys_rst stays high continuously through HOLD, WAIT_LOCK and STABLE. There are no glitches between states.
- lock_lost:
  - Set on the RUN->HOLD edge.
  - Cleared by clr_lost.
  - If set and clear occur on the same edge, set wins.
  - Unaffected by STABLE->WAIT_LOCK aborts.
- state output is the registered FSM state.

Optional Feature:
LOCK_MON_CNT_EN
- Defined: port loss_count exists.
  - Increments by 1 on each RUN->HOLD transition.
  - Saturates at all-ones.
  - Cleared only by rst; clr_lost does not affect it.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
1. SYNC_STAGES=2, STABLE_CYCLES=8; rst, then locked=1 steady -> sys_rst 1->0 and ready 0->1 at edge 11; state=2 from then on.
2. Same config; locked drops for 5 cycles after 4 cycles in STABLE -> state returns to 0, lock_lost stays 0; after locked returns, sys_rst falls exactly 11 edges later.
3. In RUN, DROP_FILTER=4:
   - locked low 3 cycles then high -> no change, state=2.
   - locked low 4 cycles -> sys_rst=1, ready=0, lock_lost=1, state=3.
4. HOLD_CYCLES=16; locked returns high one cycle after entering HOLD -> state=3 for exactly 16 cycles, then 0, then 1, then RUN after the 8-cycle stable interval; sys_rst never drops before then.
5. clr_lost pulsed on the same edge as a RUN->HOLD transition -> lock_lost=1; clr_lost pulsed 10 cycles later -> lock_lost=0.
6. With LOCK_MON_CNT_EN, CNT_W=2:
   - 4 lock losses -> loss_count saturates at 3.
   - rst asserted while in RUN -> next edge: sys_rst=1, ready=0, state=0, lock_lost=0, loss_count=0.
